// File: rtl/peach_pkg.sv
// peach_pkg -- shared constants and types for the Peach RV32I core and its LSU.
//   NUM_LANES/LANE_W : byte-lane geometry of the 32-bit data memory
//   F3_*             : RV32I load/store funct3 encodings
//   OP_*             : load/store opcodes (used by the core decoder)
//   lsu_state_t      : LSU FSM states
//   lsu_req_t        : request fields latched on accept
// Helpers: f3_legal, misaligned, align_off.
package peach_pkg;

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_RESP   = 2'd2
   } lsu_state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [1:0]  off;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      else    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                     (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // funct3[1:0] is the access size (00 byte, 01 half, 10 word) for all legal codes.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Forces the low address bits to the natural alignment of the access size.
   function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return {off[1], 1'b0};
         2'b10:   return 2'b00;
         default: return off;
      endcase
   endfunction

endpackage

// File: rtl/peach_lsu_align.sv
// peach_lsu_align -- combinational load extraction and sign/zero extension.
//   rdata  : raw 32-bit memory word
//   offset : byte offset within the word (already aligned for half/word)
//   funct3 : load funct3 (LB/LH/LW/LBU/LHU); anything else yields 0
//   result : extended load value
module peach_lsu_align
   import peach_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign lanes = rdata;

   always_comb begin
      byte_v = lanes[offset];
      half_v = offset[1] ? rdata[31:16] : rdata[15:0];
      result = '0;
      case (funct3)
         F3_LB:   result = {{24{byte_v[7]}}, byte_v};
         F3_LH:   result = {{16{half_v[15]}}, half_v};
         F3_LW:   result = rdata;
         F3_LBU:  result = {24'd0, byte_v};
         F3_LHU:  result = {16'd0, half_v};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/peach_lsu.sv
// peach_lsu -- load/store unit for the Peach multi-cycle RV32I core.
// One request at a time: IDLE (accept) -> ACCESS (memory strobe) -> RESP (one-cycle
// response). Faulting requests skip ACCESS and never touch memory.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request from core
//   rsp_valid/rsp_rdata/rsp_fault                           : response pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata              : sync single-port RAM
// Build option: PEACH_LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses fault; otherwise the low address bits are forced to alignment.
module peach_lsu
   import peach_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_fault,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   lsu_state_t state, state_nxt;
   lsu_req_t   req_q;
   logic       fault_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic       accept, bad;
   logic [31:0] ld_data;
   logic [NUM_LANES-1:0] be;
   logic [NUM_LANES-1:0][LANE_W-1:0] wlanes;

   // Upper address bits are intentionally dropped: addresses wrap.
   logic unused_addr;
   assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

   assign accept = (state == LSU_IDLE) && req_valid;

`ifdef PEACH_LSU_MISALIGN_TRAP_EN
   assign bad = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
   assign bad = !f3_legal(req_we, req_funct3);
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= LSU_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         LSU_IDLE:   if (req_valid) state_nxt = bad ? LSU_RESP : LSU_ACCESS;
         LSU_ACCESS: state_nxt = LSU_RESP;
         LSU_RESP:   state_nxt = LSU_IDLE;
         default:    state_nxt = LSU_IDLE;
      endcase
   end

   // Request capture. The offset is stored already aligned, so in the
   // non-trapping build a misaligned access simply proceeds aligned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q   <= '0;
         fault_q <= 1'b0;
         addr_q  <= '0;
      end else if (accept) begin
         req_q.we     <= req_we;
         req_q.funct3 <= req_funct3;
         req_q.off    <= align_off(req_funct3, req_addr[1:0]);
         req_q.wdata  <= req_wdata;
         addr_q       <= req_addr[ADDR_WIDTH+1:2];
         fault_q      <= bad;
      end
   end

   // Byte enables for stores
   always_comb begin
      be = '0;
      case (req_q.funct3)
         F3_SB:   be = NUM_LANES'(1) << req_q.off;
         F3_SH:   be = req_q.off[1] ? 4'b1100 : 4'b0011;
         F3_SW:   be = '1;
         default: be = '0;
      endcase
   end

   // Lane replication: every lane carries the byte/half it would hold at any offset.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign wlanes[i] = (req_q.funct3 == F3_SB) ? req_q.wdata[LANE_W-1:0] :
                         (req_q.funct3 == F3_SH) ? req_q.wdata[(i%2)*LANE_W +: LANE_W] :
                                                   req_q.wdata[i*LANE_W +: LANE_W];
   end

   peach_lsu_align u_align (
      .rdata  (mem_rdata),
      .offset (req_q.off),
      .funct3 (req_q.funct3),
      .result (ld_data)
   );

   // Outputs are decoded from state only, so an async reset clears them at once.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_fault = 1'b0;
      rsp_rdata = '0;
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         LSU_IDLE:   req_ready = 1'b1;
         LSU_ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = req_q.we ? be : '0;
            mem_addr  = addr_q;
            mem_wdata = wlanes;
         end
         LSU_RESP: begin
            rsp_valid = 1'b1;
            rsp_fault = fault_q;
            if (!req_q.we && !fault_q) rsp_rdata = ld_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_peach_lsu.sv
module tb_peach_lsu;
   import peach_pkg::*;

`ifdef PEACH_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_fault;
   logic [31:0] rsp_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   peach_lsu #(.ADDR_WIDTH(12)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous single-port RAM, read-first, one-cycle latency, holds rdata.
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         mem_rdata <= mem[mem_addr];
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic fault;
      logic [31:0] rdata;
      string name;
   } exp_t;
   exp_t sb[$];

   // Response monitor: pops the scoreboard whenever a response appears.
   always @(negedge clk) begin
      if (reset) begin
         if (rsp_valid) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.name, "_fault"}, {31'd0, rsp_fault}, {31'd0, e.fault});
               chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
            end
         end else begin
            chk("rdata_idle_zero", rsp_rdata, 32'd0);
         end
      end
   end

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        fault;
      logic [3:0]  mwe;
      logic [11:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic flt,
                               input logic [3:0] mwe, input logic [11:0] ma,
                               input logic [31:0] mwd, input logic [31:0] rd);
      vec_t v;
      v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.fault = flt;
      v.mwe = mwe; v.maddr = ma; v.mwdata = mwd; v.rdata = rd;
      return v;
   endfunction

   task automatic do_req(input vec_t v);
      int guard = 0;
      exp_t e;
      @(negedge clk);
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      if (!req_ready) chk({v.name, "_ready_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
      req_addr = v.addr; req_wdata = v.wdata;
      e.fault = v.fault; e.rdata = v.fault ? 32'd0 : v.rdata; e.name = v.name;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({v.name, "_busy"}, {31'd0, req_ready}, 32'd0);
      if (v.fault) begin
         chk({v.name, "_no_mem_en"}, {31'd0, mem_en}, 32'd0);
         chk({v.name, "_rsp_lat1"}, {31'd0, rsp_valid}, 32'd1);
      end else begin
         chk({v.name, "_mem_en"}, {31'd0, mem_en}, 32'd1);
         chk({v.name, "_mem_we"}, {28'd0, mem_we}, {28'd0, v.mwe});
         chk({v.name, "_mem_addr"}, {20'd0, mem_addr}, {20'd0, v.maddr});
         if (v.we) chk({v.name, "_mem_wdata"}, mem_wdata, v.mwdata);
         chk({v.name, "_no_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
         @(posedge clk); #1;
         chk({v.name, "_rsp_lat2"}, {31'd0, rsp_valid}, 32'd1);
         chk({v.name, "_mem_en_off"}, {31'd0, mem_en}, 32'd0);
      end
      @(posedge clk); #1;
      chk({v.name, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
      chk({v.name, "_ready_again"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string n);
      chk({n, "_ready"}, {31'd0, req_ready}, 32'd1);
      chk({n, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({n, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({n, "_rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
      chk({n, "_mem_en"}, {31'd0, mem_en}, 32'd0);
      chk({n, "_mem_we"}, {28'd0, mem_we}, 32'd0);
      chk({n, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
      chk({n, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   vec_t tbl[26];

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0;

      //            name       we f3      addr          wdata         flt   mwe     maddr   mwdata        rdata
      tbl[0]  = mk("sw100",    1, F3_SW,  32'h100, 32'hDEADBEEF, 0, 4'hF, 12'h40, 32'hDEADBEEF, 0);
      tbl[1]  = mk("lw100",    0, F3_LW,  32'h100, 0,            0, 4'h0, 12'h40, 0, 32'hDEADBEEF);
      tbl[2]  = mk("sb103",    1, F3_SB,  32'h103, 32'h80,       0, 4'h8, 12'h40, 32'h80808080, 0);
      tbl[3]  = mk("lb103",    0, F3_LB,  32'h103, 0,            0, 4'h0, 12'h40, 0, 32'hFFFFFF80);
      tbl[4]  = mk("lbu103",   0, F3_LBU, 32'h103, 0,            0, 4'h0, 12'h40, 0, 32'h00000080);
      tbl[5]  = mk("sh102",    1, F3_SH,  32'h102, 32'h8001,     0, 4'hC, 12'h40, 32'h80018001, 0);
      tbl[6]  = mk("lh102",    0, F3_LH,  32'h102, 0,            0, 4'h0, 12'h40, 0, 32'hFFFF8001);
      tbl[7]  = mk("lw100b",   0, F3_LW,  32'h100, 0,            0, 4'h0, 12'h40, 0, 32'h8001BEEF);
      tbl[8]  = mk("lhu100",   0, F3_LHU, 32'h100, 0,            0, 4'h0, 12'h40, 0, 32'h0000BEEF);
      tbl[9]  = mk("lh100",    0, F3_LH,  32'h100, 0,            0, 4'h0, 12'h40, 0, 32'hFFFFBEEF);
      tbl[10] = mk("lb101",    0, F3_LB,  32'h101, 0,            0, 4'h0, 12'h40, 0, 32'hFFFFFFBE);
      tbl[11] = mk("lbu102",   0, F3_LBU, 32'h102, 0,            0, 4'h0, 12'h40, 0, 32'h00000001);
      tbl[12] = mk("lw101",    0, F3_LW,  32'h101, 0,         TRAP, 4'h0, 12'h40, 0, 32'h8001BEEF);
      tbl[13] = mk("lh103",    0, F3_LH,  32'h103, 0,         TRAP, 4'h0, 12'h40, 0, 32'hFFFF8001);
      tbl[14] = mk("sw106",    1, F3_SW,  32'h106, 32'hCAFEF00D, TRAP, 4'hF, 12'h41, 32'hCAFEF00D, 0);
      tbl[15] = mk("lw104",    0, F3_LW,  32'h104, 0,            0, 4'h0, 12'h41, 0,
                   TRAP ? 32'h0 : 32'hCAFEF00D);
      tbl[16] = mk("sb105",    1, F3_SB,  32'h105, 32'hA5,       0, 4'h2, 12'h41, 32'hA5A5A5A5, 0);
      tbl[17] = mk("lw104b",   0, F3_LW,  32'h104, 0,            0, 4'h0, 12'h41, 0,
                   TRAP ? 32'h0000A500 : 32'hCAFEA50D);
      tbl[18] = mk("ld_f3_011",0, 3'b011, 32'h100, 0,            1, 4'h0, 12'h0, 0, 0);
      tbl[19] = mk("st_f3_100",1, 3'b100, 32'h100, 32'h1111,     1, 4'h0, 12'h0, 0, 0);
      tbl[20] = mk("ld_f3_110",0, 3'b110, 32'h100, 0,            1, 4'h0, 12'h0, 0, 0);
      tbl[21] = mk("st_f3_011",1, 3'b011, 32'h100, 32'h2222,     1, 4'h0, 12'h0, 0, 0);
      tbl[22] = mk("sw000",    1, F3_SW,  32'h0,   32'h12345678, 0, 4'hF, 12'h0, 32'h12345678, 0);
      tbl[23] = mk("lw4000",   0, F3_LW,  32'h4000,0,            0, 4'h0, 12'h0, 0, 32'h12345678);
      tbl[24] = mk("sh4006",   1, F3_SH,  32'h4006,32'hFFFF1234, 0, 4'hC, 12'h1, 32'h12341234, 0);
      tbl[25] = mk("lhu006",   0, F3_LHU, 32'h6,   0,            0, 4'h0, 12'h1, 0, 32'h00001234);

      #2;
      chk_reset_outputs("reset");
      @(negedge clk); reset = 1'b1;

      for (int i = 0; i < 26; i++) do_req(tbl[i]);

      // req_valid held with a different request while busy must be ignored.
      begin
         exp_t e;
         @(negedge clk);
         req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h100;
         e.fault = 1'b0; e.rdata = 32'h8001BEEF; e.name = "busy_lw";
         sb.push_back(e);
         @(posedge clk); #1;
         req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h200; req_wdata = 32'h55555555;
         chk("busy_mem_en", {31'd0, mem_en}, 32'd1);
         chk("busy_mem_we", {28'd0, mem_we}, 32'd0);
         chk("busy_mem_addr", {20'd0, mem_addr}, 32'h40);
         @(posedge clk); #1;
         chk("busy_rsp", {31'd0, rsp_valid}, 32'd1);
         req_valid = 1'b0;
         @(posedge clk); #1;
         chk("busy_idle", {31'd0, req_ready}, 32'd1);
      end
      do_req(mk("lw200", 0, F3_LW, 32'h200, 0, 0, 4'h0, 12'h80, 0, 32'h0));

      // Reset pulsed during ACCESS of a load.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd1);
      reset = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      @(posedge clk); #1;
      chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_after_no_rsp", {31'd0, rsp_valid}, 32'd0);
      do_req(mk("lw_after_rst", 0, F3_LW, 32'h100, 0, 0, 4'h0, 12'h40, 0, 32'h8001BEEF));

      @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
